// File: rtl/alu_sequencer.sv
// Issue/writeback control stage around a combinational 4-bit ALU.
// Two-cycle initiation interval: accept in IDLE, retire at the end of EXEC.
module alu_sequencer #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [11:0]   in_instr,
   output logic          in_ready,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [3:0]    alu_op,
   output logic          alu_cin,
   input  logic [DW-1:0] alu_res,
   input  logic          alu_cout,
   input  logic          alu_of,
   input  logic          alu_zero,
   output logic          done,
   output logic          flag_c,
   output logic          flag_v,
   output logic          flag_z,
   output logic          err,
   input  logic [1:0]    dbg_sel,
   output logic [DW-1:0] dbg_data
);

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_t;

   typedef enum logic [1:0] {
      C_ALU,
      C_LDI,
      C_NOP,
      C_ILL
   } cls_t;

   state_t        state_q;
   cls_t          in_cls;
   cls_t          cls_q;
   logic [1:0]    rd_q;
   logic [DW-1:0] imm_q;
   logic [DW-1:0] alu_a_q;
   logic [DW-1:0] alu_b_q;
   logic [3:0]    alu_op_q;
   logic [DW-1:0] regs_q [4];
   logic          flag_c_q;
   logic          flag_v_q;
   logic          flag_z_q;
   logic          err_q;
   logic          done_q;

   logic [3:0]    in_opc;
   logic [1:0]    in_rd;
   logic [1:0]    in_ra;
   logic [1:0]    in_rb;
   logic [DW-1:0] in_imm;

   assign in_opc = in_instr[11:8];
   assign in_rd  = in_instr[7:6];
   assign in_ra  = in_instr[5:4];
   assign in_rb  = in_instr[3:2];
   assign in_imm = in_instr[DW-1:0];

   always_comb begin
      in_cls = C_ILL;
      unique case (1'b1)
         (in_opc[3] == 1'b0): in_cls = C_ALU;
         (in_opc == 4'h8):    in_cls = C_LDI;
         (in_opc == 4'h9):    in_cls = C_NOP;
         default:             in_cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cls_q    <= C_NOP;
         rd_q     <= '0;
         imm_q    <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_z_q <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  cls_q   <= in_cls;
                  rd_q    <= in_rd;
                  imm_q   <= in_imm;
                  state_q <= S_EXEC;
                  // Operands are captured here, so rd may alias ra/rb.
                  if (in_cls == C_ALU) begin
                     alu_a_q  <= regs_q[in_ra];
                     alu_b_q  <= regs_q[in_rb];
                     alu_op_q <= in_opc;
                  end
               end
            end
            S_EXEC: begin
               unique case (cls_q)
                  C_ALU: begin
                     regs_q[rd_q] <= alu_res;
                     flag_c_q     <= alu_cout;
                     flag_v_q     <= alu_of;
                     flag_z_q     <= alu_zero;
                  end
                  C_LDI: regs_q[rd_q] <= imm_q;
                  C_NOP: ;
                  C_ILL: err_q <= 1'b1;
               endcase
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == S_IDLE);
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign alu_cin  = flag_c_q;
   assign done     = done_q;
   assign flag_c   = flag_c_q;
   assign flag_v   = flag_v_q;
   assign flag_z   = flag_z_q;
   assign err      = err_q;
   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer.
// The bench plays the ALU and predicts architectural state from opcode rules.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] in_instr;
   logic        in_ready;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [3:0]  alu_op;
   logic        alu_cin;
   logic [3:0]  alu_res;
   logic        alu_cout;
   logic        alu_of;
   logic        alu_zero;
   logic        done;
   logic        flag_c;
   logic        flag_v;
   logic        flag_z;
   logic        err;
   logic [1:0]  dbg_sel;
   logic [3:0]  dbg_data;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_reg [4];
   logic       m_c, m_v, m_z, m_err;
   logic [3:0] m_a, m_b, m_op;

   always #10 clk = ~clk;

   alu_sequencer #(.DW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_cout(alu_cout), .alu_of(alu_of),
      .alu_zero(alu_zero), .done(done),
      .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .err(err),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [11:0] mk(input int op, input int rd,
                                      input int ra, input int rb);
      logic [11:0] w;
      w = {op[3:0], rd[1:0], ra[1:0], rb[1:0], 2'b00};
      return w;
   endfunction

   function automatic logic [11:0] mk_ldi(input int rd, input int imm);
      logic [11:0] w;
      w = {4'h8, rd[1:0], 2'b00, imm[3:0]};
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
      m_c = 0; m_v = 0; m_z = 0; m_err = 0;
      m_a = 0; m_b = 0; m_op = 0;
   endtask

   // Presents one instruction from mid-cycle, plays the ALU, checks retire.
   task automatic issue(input logic [11:0] instr, input logic [3:0] res,
                        input logic c, input logic v, input logic z,
                        input bit hold);
      logic [3:0] op;
      logic [1:0] rd, ra, rb;
      logic [3:0] imm;
      op = instr[11:8]; rd = instr[7:6]; ra = instr[5:4];
      rb = instr[3:2];  imm = instr[3:0];
      in_valid = 1'b1;
      in_instr = instr;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_accept got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      if (op < 8) begin
         m_a = m_reg[ra]; m_b = m_reg[rb]; m_op = op;
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_exec got %b want 0", in_ready);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_in_exec got %b want 0", done);
      end
      checks++;
      if (alu_a !== m_a || alu_b !== m_b) begin
         errors++;
         $display("FAIL operands got a=%h b=%h want a=%h b=%h",
                  alu_a, alu_b, m_a, m_b);
      end
      checks++;
      if (alu_op !== m_op || alu_cin !== m_c) begin
         errors++;
         $display("FAIL opcode_cin got op=%h cin=%b want op=%h cin=%b",
                  alu_op, alu_cin, m_op, m_c);
      end
      alu_res = res; alu_cout = c; alu_of = v; alu_zero = z;
      dbg_sel = rd;
      #1;
      checks++;
      if (dbg_data !== m_reg[rd]) begin
         errors++;
         $display("FAIL dbg_before_wb got %h want %h", dbg_data, m_reg[rd]);
      end
      if (op < 8) begin
         m_reg[rd] = res; m_c = c; m_v = v; m_z = z;
      end else if (op == 8) begin
         m_reg[rd] = imm;
      end else if (op > 9) begin
         m_err = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL retire got done=%b ready=%b want 1 1", done, in_ready);
      end
      checks++;
      if ({flag_c, flag_v, flag_z, err} !== {m_c, m_v, m_z, m_err}) begin
         errors++;
         $display("FAIL flags_err got %b%b%b%b want %b%b%b%b",
                  flag_c, flag_v, flag_z, err, m_c, m_v, m_z, m_err);
      end
      checks++;
      if (dbg_data !== m_reg[rd]) begin
         errors++;
         $display("FAIL dbg_after_wb r%0d got %h want %h",
                  rd, dbg_data, m_reg[rd]);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle got done=%b ready=%b want 0 1", done, in_ready);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_instr = '0; dbg_sel = '0;
      alu_res = '0; alu_cout = 0; alu_of = 0; alu_zero = 0;
      model_reset();
      #1;
      checks++;
      if ({in_ready, done, err, flag_c, flag_v, flag_z} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 100000",
                  {in_ready, done, err, flag_c, flag_v, flag_z});
      end
      checks++;
      if ({alu_a, alu_b, alu_op} !== 12'h000) begin
         errors++;
         $display("FAIL reset_alu got %h want 000", {alu_a, alu_b, alu_op});
      end
      for (int i = 0; i < 4; i++) begin
         dbg_sel = i[1:0]; #1;
         checks++;
         if (dbg_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_reg r%0d got %h want 0", i, dbg_data);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_basic();
      issue(mk_ldi(1, 3), 4'h0, 0, 0, 0, 0);
      idle(1);
      issue(mk_ldi(2, 4), 4'h0, 0, 0, 0, 0);
      idle(1);
      issue(mk(7, 0, 1, 2), 4'h7, 0, 0, 0, 0);
      idle(2);
   endtask

   task automatic test_carry();
      issue(mk(0, 3, 1, 2), 4'h2, 1, 0, 0, 0);
      issue(mk(6, 3, 3, 1), 4'h6, 0, 1, 0, 0);
      idle(1);
   endtask

   task automatic test_illegal();
      issue(mk_ldi(3, 5), 4'h0, 0, 0, 0, 0);
      issue(mk(12, 3, 1, 2), 4'hA, 1, 1, 1, 0);
      issue(mk_ldi(0, 6), 4'h0, 0, 0, 0, 0);
      issue(mk(1, 1, 0, 3), 4'h0, 0, 0, 1, 0);
      issue(mk(9, 2, 0, 0), 4'h1, 1, 1, 1, 0);
      idle(1);
   endtask

   task automatic test_back_to_back();
      issue(mk_ldi(1, 9), 4'h0, 0, 0, 0, 1);
      issue(mk(2, 2, 1, 0), 4'hB, 1, 0, 0, 1);
      issue(mk(6, 3, 2, 1), 4'hC, 0, 1, 0, 1);
      issue(mk(4, 0, 3, 3), 4'h0, 0, 0, 1, 1);
      idle(2);
   endtask

   task automatic test_reset_mid_exec();
      issue(mk(5, 1, 0, 0), 4'h3, 1, 1, 0, 0);
      issue(mk_ldi(0, 9), 4'h0, 0, 0, 0, 0);
      in_valid = 1'b1;
      in_instr = mk(0, 0, 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_res = 4'hE; alu_cout = 1; alu_of = 1; alu_zero = 0;
      rst_n = 1'b0;
      model_reset();
      dbg_sel = 2'd0;
      #1;
      checks++;
      if (dbg_data !== 4'h0 || {flag_c, flag_v, flag_z, err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid got r0=%h flags=%b want 0 0000",
                  dbg_data, {flag_c, flag_v, flag_z, err});
      end
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_ctrl got done=%b ready=%b want 0 1",
                  done, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      idle(2);
      dbg_sel = 2'd0; #1;
      checks++;
      if (dbg_data !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_r0 got %h want 0", dbg_data);
      end
   endtask

   task automatic test_self_dep();
      issue(mk_ldi(2, 15), 4'h0, 0, 0, 0, 0);
      issue(mk(0, 2, 2, 2), 4'hE, 1, 0, 0, 0);
      idle(1);
   endtask

   task automatic test_random();
      logic [11:0] w;
      logic [3:0]  r;
      logic [2:0]  f;
      for (int n = 0; n < 80; n++) begin
         w = 12'($urandom);
         if ($urandom_range(0, 3) == 0) w[11:8] = 4'h8;
         r = 4'($urandom);
         f = 3'($urandom);
         issue(w, r, f[2], f[1], f[0], bit'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = i[1:0]; #1;
         checks++;
         if (dbg_data !== m_reg[i]) begin
            errors++;
            $display("FAIL random_final r%0d got %h want %h",
                     i, dbg_data, m_reg[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_illegal();
      test_back_to_back();
      test_reset_mid_exec();
      test_self_dep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
